// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with synchronous clear; head is combinational and zeroed when empty.
module sync_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  T                             wData,
  output T                             rData,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [AW-1:0] wPtr;
  logic [AW-1:0] rPtr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wPtr  <= '0;
      rPtr  <= '0;
      count <= '0;
    end else if (clear) begin
      wPtr  <= '0;
      rPtr  <= '0;
      count <= '0;
    end else begin
      if (push) wPtr <= wPtr + AW'(1);
      if (pop)  rPtr <= rPtr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wPtr] <= wData;
  end

  assign valid = (count != '0);
  assign rData = valid ? mem[rPtr] : '0;

  depthPow2: assert property (@(posedge clk) (DEPTH & (DEPTH - 1)) == 0);
  countBound: assert property (@(posedge clk) disable iff (!rstN) count <= CW'(DEPTH));
  noEmptyPop: assert property (@(posedge clk) disable iff (!rstN) pop |-> valid);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC and feeds Decode through a DEPTH-entry instruction queue.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int unsigned          DEPTH       = 4,
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [PC_WIDTH-1:0]          imem_addr_o,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata_i,
  input  logic                         redirect_i,
  input  logic [PC_WIDTH-1:0]          redirect_pc_i,
  input  logic                         dec_ready_i,
  output logic                         dec_valid_o,
  output logic [INSTR_WIDTH-1:0]       InstrD_o,
  output logic [PC_WIDTH-1:0]          PCD_o,
  output logic [PC_WIDTH-1:0]          PCPlus4D_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_plus4;
  } entry_t;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcPlus4;
  logic                push;
  logic                pop;
  logic                full;
  entry_t              wEntry;
  entry_t              head;

  assign pcPlus4 = pc + PC_WIDTH'(4);
  assign full    = (count_o == CW'(DEPTH));
  assign pop     = dec_valid_o && dec_ready_i;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push    = !redirect_i && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= redirect_pc_i & ~PC_WIDTH'(3);
    end else if (push) begin
      pc <= pcPlus4;
    end
  end

  assign wEntry = '{pc: pc, instr: imem_rdata_i, pc_plus4: pcPlus4};

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) fifo (
    .clk   (clk_i),
    .rstN  (rst_ni),
    .clear (redirect_i),
    .push  (push),
    .pop   (pop),
    .wData (wEntry),
    .rData (head),
    .valid (dec_valid_o),
    .count (count_o)
  );

  assign imem_addr_o = pc;
  assign InstrD_o    = head.instr;
  assign PCD_o       = head.pc;
  assign PCPlus4D_o  = head.pc_plus4;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage that replaces the single-entry Fetch→Decode pipeline register with a DEPTH-entry instruction queue.
- Owns the PC register and drives the instruction-memory address. It pushes {PC, instruction, PC+4} triples into a circular buffer, and Decode pops them with a valid/ready handshake.
- Adds stall-by-backpressure and redirect/flush behaviour, which the single-register stage lacks. Sits between instr_mem and the decode stage.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- PC_WIDTH, 32, PC and address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  one clock; reset is asynchronous and active-low.
- imem_addr_o  out  PC_WIDTH  current fetch PC to instr_mem (combinational-read memory).
- imem_rdata_i  in  INSTR_WIDTH  instruction at imem_addr_o, same cycle.
- redirect_i  in  1  taken branch/jump from Execute; flush queue and load new PC.
- redirect_pc_i  in  PC_WIDTH  redirect target (PCTarget).
- dec_ready_i  in  1  Decode can accept the head entry this cycle.
- dec_valid_o  out  1  head entry valid.
- InstrD_o  out  INSTR_WIDTH  head instruction.
- PCD_o  out  PC_WIDTH  head PC.
- PCPlus4D_o  out  PC_WIDTH  head PC+4.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - PC = RESET_PC; read/write pointers = 0; count = 0; dec_valid_o = 0.
  - InstrD_o, PCD_o and PCPlus4D_o read 0 while empty (output mux gated by valid).
- Signals:
  - imem_addr_o = PC, combinational.
  - pop = dec_valid_o && dec_ready_i.
  - push = !redirect_i && (count < DEPTH || pop). When full, a push is allowed in the same cycle as a pop.
- On push:
  - entry[wptr] = {PC, imem_rdata_i, PC+4}.
  - wptr = wptr+1 mod DEPTH.
  - PC = PC+4. This addition wraps modulo 2^PC_WIDTH.
- On pop: rptr = rptr+1 mod DEPTH.
- count:
  - push only: +1.
  - pop only: −1.
  - push and pop: unchanged.
  - Never exceeds DEPTH; never underflows.
- Head outputs: driven combinationally from entry[rptr]. dec_valid_o = (count != 0).
- Latency: an instruction fetched at edge N is visible to Decode after edge N+1. There is no bypass from imem_rdata_i to the outputs.
- Redirect (highest priority):
  - Next edge: rptr = wptr = 0; count = 0; PC = {redirect_pc_i[PC_WIDTH-1:2], 2'b00}; no push that cycle.
  - A pop handshake in the redirect cycle is still accepted; Decode treats that instruction as flushed, and its own flush logic handles it.
  - The first target instruction is pushed the cycle after redirect and is valid to Decode one cycle later.
- Full and no pop: PC holds, imem_addr_o is stable, no entry is overwritten.
- Empty and dec_ready_i=1: no pop; pointers hold.
- Redirect while full, or while empty: identical flush result.
- Reset asserted mid-operation: immediate return to reset state; all queued entries are discarded.
- Optional assertions (synthesis-off):
  - DEPTH is a power of two.
  - count ≤ DEPTH.
  - No pop while !dec_valid_o.

Decomposition:
- Shared package pipe_pkg:
  - fetch_entry_t struct {pc, instr, pc_plus4}.
  - RESET_PC default constant.
  - INSTR_NOP = 32'h00000013, for benches/Decode.
- One natural sub-module: sync_fifo. It holds the pointers, count and the storage array, is parametrised by DEPTH and entry type, and has a clear port for redirect. fetch_queue keeps the PC register and push/redirect logic.

Test Plan:
- Fill with backpressure: reset, dec_ready_i=0, imem returns PC>>2 as data for 6 cycles. Required: count_o reaches 4 and holds; PC holds at 0x10; head PCD_o=0x0, InstrD_o=0x0, PCPlus4D_o=0x4.
- Streaming: dec_ready_i=1 continuously. Required: dec_valid_o rises one cycle after reset release; PCD_o sequence 0x0, 0x4, 0x8, … one per cycle; count_o steady at 1.
- Full simultaneous push/pop: queue full (4), dec_ready_i=1 for one cycle. Required: count_o stays 4; head advances to 0x4; new tail PC 0x10; PC moves to 0x14.
- Redirect: queue holds 3 entries, redirect_i=1 with redirect_pc_i=0x103. Required: next cycle count_o=0, dec_valid_o=0, imem_addr_o=0x100; one cycle later head PCD_o=0x100, PCPlus4D_o=0x104.
- Pointer wrap: stream 10 entries with dec_ready_i toggling 1,0,1,0,…. Required: popped PCs are strictly 0x0, 0x4, …, 0x24 in order, with no duplicates or drops.
- Async reset mid-run: assert rst_ni=0 between clock edges with count_o=2. Required: dec_valid_o=0, count_o=0 and imem_addr_o=RESET_PC immediately, without waiting for a clock edge.
